// File: rtl/sprite_rom_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// sprite_rom_arbiter_pkg
// Shared sprite constants: requester count, sprite ROM geometry, requester
// index names and the one-hot return tag type used by the ROM arbiter.
// ---------------------------------------------------------------------------
package sprite_rom_arbiter_pkg;

    localparam int SPR_NREQ   = 5;   // Pac + four ghosts
    localparam int SPR_ADDR_W = 10;  // 32x32 sprite
    localparam int SPR_DATA_W = 12;  // RGB444

    // Requester indices
    localparam int PAC    = 0;
    localparam int GHOST1 = 1;
    localparam int GHOST2 = 2;
    localparam int GHOST3 = 3;
    localparam int GHOST4 = 4;

    // One-hot tag identifying which requester a ROM return belongs to
    typedef logic [SPR_NREQ-1:0] tag_t;

endpackage

// File: rtl/sprite_rom_arbiter_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational grant selection.
//   req       : per-requester request bits
//   ptr       : round-robin start index (first index examined)
//   fixed_pri : 1 = lowest requesting index wins, 0 = round-robin from ptr
//   gnt       : one-hot-or-zero grant
//   gnt_idx   : binary index of the granted requester (0 when no grant)
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N     = 5,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    input  logic             fixed_pri,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx
);

    always_comb begin
        int  idx;
        logic found;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        // Scan N candidates starting at ptr (or at 0 in fixed mode); the
        // first requesting one wins.
        for (int k = 0; k < N; k++) begin
            idx = fixed_pri ? k : ((int'(ptr) + k) % N);
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = idx[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// ---------------------------------------------------------------------------
// sprite_rom_arbiter
// Shares one synchronous sprite ROM between NREQ requesters.
//   clk, rst   : clock, asynchronous active-high reset
//   fixed_pri  : 1 = fixed priority (lowest index), 0 = round-robin
//   req        : per-requester read request, held until granted
//   addr       : packed per-requester ROM addresses (slice i = requester i)
//   gnt        : combinational one-hot-or-zero grant
//   rom_en     : registered ROM read enable
//   rom_addr   : registered ROM address
//   rom_data   : ROM output, valid one cycle after rom_en
//   rdata      : returned pixel (rom_data while rvalid is nonzero, else 0)
//   rvalid     : one-hot return tag, two cycles after the grant
//   starve     : sticky per-requester starvation flags
// ---------------------------------------------------------------------------
module sprite_rom_arbiter
    import sprite_rom_arbiter_pkg::*;
#(
    parameter int NREQ       = SPR_NREQ,
    parameter int ADDR_W     = SPR_ADDR_W,
    parameter int DATA_W     = SPR_DATA_W,
    parameter int STARVE_LIM = 15
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   fixed_pri,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*ADDR_W-1:0] addr,
    output logic [NREQ-1:0]        gnt,
    output logic                   rom_en,
    output logic [ADDR_W-1:0]      rom_addr,
    input  logic [DATA_W-1:0]      rom_data,
    output logic [DATA_W-1:0]      rdata,
    output logic [NREQ-1:0]        rvalid,
    output logic [NREQ-1:0]        starve
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_W = $clog2(STARVE_LIM + 1);
    localparam logic [CNT_W-1:0] LIM = CNT_W'(STARVE_LIM);

    logic [IDX_W-1:0]  ptr_reg;
    logic [IDX_W-1:0]  ptr_next;
    logic [NREQ-1:0]   arb_gnt;
    logic [IDX_W-1:0]  gnt_idx;
    logic              any_gnt;

    logic              rom_en_reg;
    logic [ADDR_W-1:0] rom_addr_reg;
    tag_t              tag1_reg;     // tag of the read currently at the ROM
    tag_t              rvalid_reg;   // tag of the data on rom_data now

    rr_arbiter #(
        .N     (NREQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req       (req),
        .ptr       (ptr_reg),
        .fixed_pri (fixed_pri),
        .gnt       (arb_gnt),
        .gnt_idx   (gnt_idx)
    );

    // Grants are suppressed while reset is held so nothing downstream
    // (wait counters, ptr, pipeline) sees a grant during reset.
    assign gnt     = rst ? '0 : arb_gnt;
    assign any_gnt = |gnt;

    assign ptr_next = (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 1'b1;

    // Two-stage read pipeline: grant -> ROM address register -> ROM data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_reg      <= '0;
            rom_en_reg   <= 1'b0;
            rom_addr_reg <= '0;
            tag1_reg     <= '0;
            rvalid_reg   <= '0;
        end else begin
            if (any_gnt) begin
                ptr_reg      <= ptr_next;
                rom_en_reg   <= 1'b1;
                rom_addr_reg <= addr[gnt_idx*ADDR_W +: ADDR_W];
                tag1_reg     <= tag_t'(gnt);
            end else begin
                rom_en_reg   <= 1'b0;
                tag1_reg     <= '0;
            end
            rvalid_reg <= tag1_reg;
        end
    end

    assign rom_en   = rom_en_reg;
    assign rom_addr = rom_addr_reg;
    assign rvalid   = rvalid_reg;
    // The ROM already registers its output, so the data for the tag in
    // rvalid_reg is on rom_data this cycle; gate it so idle cycles read 0.
    assign rdata    = (|rvalid_reg) ? rom_data : '0;

    // Per-requester wait counters and sticky starvation flags.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_wait
            logic [CNT_W-1:0] wait_reg;
            logic [CNT_W-1:0] wait_next;
            logic             starve_reg;

            always_comb begin
                wait_next = wait_reg;
                // A grant or a withdrawn request both restart the count.
                if (gnt[gi] || !req[gi]) begin
                    wait_next = '0;
                end else if (wait_reg != LIM) begin
                    wait_next = wait_reg + 1'b1;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    wait_reg   <= '0;
                    starve_reg <= 1'b0;
                end else begin
                    wait_reg <= wait_next;
                    if (wait_next == LIM) begin
                        starve_reg <= 1'b1;
                    end
                end
            end

            assign starve[gi] = starve_reg;
        end
    endgenerate

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sprite_rom_arbiter
// Scenario tasks drive the arbiter and check grants/ROM port/starvation
// inline against a reference grant model; every predicted grant pushes an
// expected return onto a scoreboard queue that a forked monitor pops and
// compares against rvalid/rdata in the cycle it falls due.
// ---------------------------------------------------------------------------
module tb_sprite_rom_arbiter;

    localparam int NREQ   = 5;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 12;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   fixed_pri = 1'b0;
    logic [NREQ-1:0]        req = '0;
    logic [NREQ*ADDR_W-1:0] addr;
    logic [NREQ-1:0]        gnt;
    logic                   rom_en;
    logic [ADDR_W-1:0]      rom_addr;
    logic [DATA_W-1:0]      rom_data = '0;
    logic [DATA_W-1:0]      rdata;
    logic [NREQ-1:0]        rvalid;
    logic [NREQ-1:0]        starve;

    logic [ADDR_W-1:0] addr_a [NREQ];

    typedef struct {
        logic [NREQ-1:0]   tag;
        logic [DATA_W-1:0] data;
        int                due;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   ptr_m = 0;
    int   compared = 0;
    int   mismatched = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        for (int i = 0; i < NREQ; i++) addr[i*ADDR_W +: ADDR_W] = addr_a[i];
    end

    function automatic logic [DATA_W-1:0] rom_f(input logic [ADDR_W-1:0] a);
        return {a[3:0], a[9:2]} ^ 12'h5A3;
    endfunction

    // Behavioural synchronous ROM
    always @(posedge clk) if (rom_en) rom_data <= rom_f(rom_addr);

    sprite_rom_arbiter #(
        .NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIM(15)
    ) dut (
        .clk(clk), .rst(rst), .fixed_pri(fixed_pri), .req(req), .addr(addr),
        .gnt(gnt), .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
        .rdata(rdata), .rvalid(rvalid), .starve(starve)
    );

    function automatic int exp_grant(input logic [NREQ-1:0] r, input logic fp, input int p);
        int idx;
        for (int k = 0; k < NREQ; k++) begin
            idx = fp ? k : (p + k) % NREQ;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] onehot(input int g);
        logic [NREQ-1:0] v;
        v = '0;
        if (g >= 0) v[g] = 1'b1;
        return v;
    endfunction

    // Advance model state for this cycle's grant and move to the next negedge.
    task automatic advance(input int g);
        exp_t e;
        if (g >= 0) begin
            e.tag  = onehot(g);
            e.data = rom_f(addr_a[g]);
            e.due  = cyc + 2;
            q.push_back(e);
            ptr_m = (g + 1) % NREQ;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            compared++;
            if (q.size() > 0 && q[0].due == cyc) begin
                e = q.pop_front();
                if (rvalid !== e.tag || rdata !== e.data) begin
                    mismatched++;
                    $display("FAIL return cyc=%0d: rvalid=%b rdata=%h, want rvalid=%b rdata=%h",
                             cyc, rvalid, rdata, e.tag, e.data);
                end else
                    $display("return cyc=%0d rvalid=%b rdata=%h", cyc, rvalid, rdata);
            end else if (rvalid !== '0) begin
                mismatched++;
                $display("FAIL idle_return cyc=%0d: rvalid=%b, want 00000", cyc, rvalid);
            end
        end
    endtask

    task automatic test_reset();
        req = '1;
        @(posedge clk);
        @(negedge clk);
        #1;
        compared++;
        if (gnt !== '0 || rom_en !== 1'b0 || rom_addr !== '0 || rvalid !== '0 ||
            rdata !== '0 || starve !== '0) begin
            mismatched++;
            $display("FAIL reset_state: gnt=%b rom_en=%b rom_addr=%h rvalid=%b rdata=%h starve=%b, want all 0",
                     gnt, rom_en, rom_addr, rvalid, rdata, starve);
        end else
            $display("reset state ok");
        req = '0;
        @(negedge clk);
        rst = 1'b0;
        ptr_m = 0;
    endtask

    task automatic test_single();
        int g;
        addr_a[0] = 10'h3FF;
        req = 5'b00001; #1;
        g = exp_grant(req, fixed_pri, ptr_m);
        compared++;
        if (gnt !== onehot(g)) begin
            mismatched++;
            $display("FAIL single_gnt: gnt=%b want %b", gnt, onehot(g));
        end else
            $display("single gnt=%b", gnt);
        advance(g);
        req = '0; #1;
        compared++;
        if (rom_en !== 1'b1 || rom_addr !== 10'h3FF || gnt !== '0) begin
            mismatched++;
            $display("FAIL single_rom: rom_en=%b rom_addr=%h gnt=%b, want 1 3ff 00000", rom_en, rom_addr, gnt);
        end else
            $display("single rom_en=%b rom_addr=%h", rom_en, rom_addr);
        advance(-1);
        advance(-1);
    endtask

    task automatic test_round_robin();
        int g;
        // Bring the pointer back to 0 by granting the last requester.
        req = 5'b10000; #1;
        g = exp_grant(req, fixed_pri, ptr_m);
        advance(g);
        for (int k = 0; k < 10; k++) begin
            req = '1; #1;
            g = exp_grant(req, fixed_pri, ptr_m);
            compared++;
            if (gnt !== onehot(g) || g != k % NREQ) begin
                mismatched++;
                $display("FAIL rr_gnt[%0d]: gnt=%b want %b", k, gnt, onehot(k % NREQ));
            end else
                $display("rr cycle %0d gnt=%b", k, gnt);
            if (k > 0) begin
                compared++;
                if (rom_en !== 1'b1) begin
                    mismatched++;
                    $display("FAIL rr_rom_en[%0d]: rom_en=%b want 1", k, rom_en);
                end
            end
            advance(g);
        end
        req = '0;
        advance(-1);
    endtask

    task automatic test_gap();
        int g;
        logic [ADDR_W-1:0] held;
        req = 5'b00100; #1;
        g = exp_grant(req, fixed_pri, ptr_m);
        held = addr_a[2];
        advance(g);
        for (int k = 0; k < 4; k++) begin
            req = (k < 3) ? 5'b00000 : 5'b11111; #1;
            g = exp_grant(req, fixed_pri, ptr_m);
            compared++;
            if (gnt !== onehot(g) || rom_addr !== held || rom_en !== (k == 0)) begin
                mismatched++;
                $display("FAIL gap[%0d]: gnt=%b rom_en=%b rom_addr=%h, want %b %b %h",
                         k, gnt, rom_en, rom_addr, onehot(g), (k == 0), held);
            end else
                $display("gap slot %0d gnt=%b rom_en=%b rom_addr=%h", k, gnt, rom_en, rom_addr);
            advance(g);
        end
        req = '0;
        advance(-1);
    endtask

    task automatic test_fixed_starve();
        int g;
        fixed_pri = 1'b1;
        for (int k = 0; k < 20; k++) begin
            req = 5'b00011; #1;
            g = exp_grant(req, fixed_pri, ptr_m);
            compared++;
            if (gnt !== onehot(g) || gnt !== 5'b00001 ||
                starve !== ((k >= 15) ? 5'b00010 : 5'b00000)) begin
                mismatched++;
                $display("FAIL fixed[%0d]: gnt=%b starve=%b, want 00001 %b",
                         k, gnt, starve, (k >= 15) ? 5'b00010 : 5'b00000);
            end else
                $display("fixed cycle %0d gnt=%b starve=%b", k, gnt, starve);
            advance(g);
        end
        for (int k = 0; k < 2; k++) begin
            req = '0; #1;
            compared++;
            if (starve !== 5'b00010 || gnt !== '0) begin
                mismatched++;
                $display("FAIL starve_sticky[%0d]: starve=%b gnt=%b, want 00010 00000", k, starve, gnt);
            end else
                $display("starve sticky starve=%b", starve);
            advance(-1);
        end
        fixed_pri = 1'b0;
    endtask

    task automatic test_reset_mid();
        int g;
        req = 5'b00100; #1;
        g = exp_grant(req, fixed_pri, ptr_m);
        advance(g);
        req = 5'b01000; #1;
        g = exp_grant(req, fixed_pri, ptr_m);
        compared++;
        if (gnt !== 5'b01000) begin
            mismatched++;
            $display("FAIL mid_gnt3: gnt=%b want 01000", gnt);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        req = 5'b11111;
        q.delete();          // in-flight reads are discarded
        ptr_m = 0;
        #1;
        compared++;
        if (gnt !== '0 || rvalid !== '0 || rdata !== '0 || starve !== '0 || rom_en !== 1'b0) begin
            mismatched++;
            $display("FAIL mid_reset: gnt=%b rvalid=%b rdata=%h starve=%b rom_en=%b, want all 0",
                     gnt, rvalid, rdata, starve, rom_en);
        end else
            $display("mid reset outputs cleared");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        g = exp_grant(req, fixed_pri, ptr_m);
        compared++;
        if (gnt !== onehot(g) || gnt !== 5'b00001) begin
            mismatched++;
            $display("FAIL post_reset_gnt: gnt=%b want 00001", gnt);
        end else
            $display("post reset gnt=%b", gnt);
        advance(g);
        req = '0;
        for (int k = 0; k < 4; k++) advance(-1);
    endtask

    initial begin
        for (int i = 0; i < NREQ; i++) addr_a[i] = ADDR_W'($urandom);
        test_reset();
        fork
            monitor();
        join_none
        test_single();
        test_round_robin();
        test_gap();
        test_fixed_starve();
        test_reset_mid();
        @(negedge clk);
        #2;
        compared++;
        if (q.size() != 0) begin
            mismatched++;
            $display("FAIL leftover_returns: %0d pending, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
